// File: rtl/tanimoto_pkg.sv
// Shared types and helpers for the Tanimoto comparator control path.
// Holds the controller state encoding, counter-width derivation and threshold ceiling.
package tanimoto_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2
    } ctrl_state_t;

    function automatic int cnt_width_f(input int vector_width);
        return $clog2(vector_width);
    endfunction

    // Largest value representable on the CNT_WIDTH+1 bit threshold bus.
    function automatic int th_sat_f(input int cnt_width);
        return (1 << (cnt_width + 1)) - 1;
    endfunction

endpackage

// File: rtl/threshold_load_ctrl_if.sv
// Upstream pair handshake plus comparator-side valid, retire and table write port.
// Optional i_Dout exists only when CTRL_STATS_EN is defined.
interface threshold_load_ctrl_if #(
    parameter int TH_WIDTH = 7
);
    logic                i_Valid;
    logic                o_Ready;
    logic                o_CmpValid;
    logic                i_CmpValid;
    logic                o_WrThreshold;
    logic [TH_WIDTH-1:0] o_Threshold;
`ifdef CTRL_STATS_EN
    logic                i_Dout;

    modport master (
        input  i_Valid, i_CmpValid, i_Dout,
        output o_Ready, o_CmpValid, o_WrThreshold, o_Threshold
    );
    modport slave (
        output i_Valid, i_CmpValid, i_Dout,
        input  o_Ready, o_CmpValid, o_WrThreshold, o_Threshold
    );
`else
    modport master (
        input  i_Valid, i_CmpValid,
        output o_Ready, o_CmpValid, o_WrThreshold, o_Threshold
    );
    modport slave (
        output i_Valid, i_CmpValid,
        input  o_Ready, o_CmpValid, o_WrThreshold, o_Threshold
    );
`endif
endinterface

// File: rtl/threshold_accum.sv
// Running sum of the ratio; value = saturated ceil(acc + ratio), combinational from acc.
// acc advances one ratio step per 'step' cycle and clears to zero on 'clear' or rst.
module threshold_accum
    import tanimoto_pkg::*;
#(
    parameter int CNT_WIDTH  = 6,
    parameter int FRAC_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  step,
    input  logic [FRAC_WIDTH-1:0] ratio,
    output logic [CNT_WIDTH:0]    value
);
    localparam int ACC_W = CNT_WIDTH + 1 + FRAC_WIDTH;
    localparam logic [CNT_WIDTH+1:0] SAT = (CNT_WIDTH+2)'(th_sat_f(CNT_WIDTH));

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_next;
    logic [CNT_WIDTH+1:0] ceil_v;

    // One extra headroom bit so the round-up carry is visible to the saturation compare.
    always_comb begin
        acc_next = acc + ACC_W'(ratio);
        ceil_v   = {1'b0, acc_next[ACC_W-1:FRAC_WIDTH]}
                 + (CNT_WIDTH+2)'(|acc_next[FRAC_WIDTH-1:0]);
        value    = (ceil_v > SAT) ? SAT[CNT_WIDTH:0] : ceil_v[CNT_WIDTH:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/threshold_load_ctrl.sv
// Drains in-flight comparisons, then streams a VECTOR_WIDTH-entry threshold table; reload is 1+VECTOR_WIDTH+1 cycles minimum.
// o_Ready low while busy; optional pair/hit counters behind CTRL_STATS_EN.
module threshold_load_ctrl
    import tanimoto_pkg::*;
#(
    parameter int VECTOR_WIDTH = 35,
    parameter int FRAC_WIDTH   = 8,
    parameter int PIPE_DEPTH   = 4,
    parameter int CNT_WIDTH    = cnt_width_f(VECTOR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAC_WIDTH-1:0] i_Ratio,
    input  logic                  i_Load,
    output logic                  o_Busy,
    output logic                  o_Done,
`ifdef CTRL_STATS_EN
    output logic [31:0]           o_HitCount,
    output logic [31:0]           o_PairCount,
`endif
    threshold_load_ctrl_if.master bus
);
    localparam int OUT_W = $clog2(PIPE_DEPTH + 1);

    ctrl_state_t           state, next_state;
    logic                  tbl_valid;
    logic                  done_q;
    logic [FRAC_WIDTH-1:0] ratio_q;
    logic [OUT_W-1:0]      outstanding;
    logic [CNT_WIDTH-1:0]  fill_idx;
    logic                  fill_last;
    logic                  load_acc;
    logic                  acc_clear, acc_step;
    logic                  ready, busy, wr;
    logic                  cmp_vld;
    logic [CNT_WIDTH:0]    th_value;

    assign fill_last = (fill_idx == CNT_WIDTH'(VECTOR_WIDTH - 1));
    assign load_acc  = (state == IDLE) && i_Load;
    assign cmp_vld   = bus.i_Valid && ready;

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        wr         = 1'b0;
        acc_clear  = 1'b0;
        acc_step   = 1'b0;
        case (state)
            IDLE: begin
                ready = tbl_valid;
                if (i_Load) next_state = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                acc_clear = 1'b1;
                if (outstanding == '0) next_state = FILL;
            end
            FILL: begin
                busy     = 1'b1;
                wr       = 1'b1;
                acc_step = 1'b1;
                if (fill_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tbl_valid   <= 1'b0;
            done_q      <= 1'b0;
            ratio_q     <= '0;
            outstanding <= '0;
            fill_idx    <= '0;
        end else begin
            state    <= next_state;
            done_q   <= (state == FILL) && fill_last;
            fill_idx <= (state == FILL) ? fill_idx + CNT_WIDTH'(1) : '0;
            if (load_acc) ratio_q <= i_Ratio;
            if ((state == FILL) && fill_last) tbl_valid <= 1'b1;
            // Issue and retire in the same cycle cancel out.
            case ({cmp_vld, bus.i_CmpValid})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    threshold_accum #(
        .CNT_WIDTH  (CNT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_accum (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .step  (acc_step),
        .ratio (ratio_q),
        .value (th_value)
    );

    assign bus.o_Ready       = ready;
    assign bus.o_CmpValid    = cmp_vld;
    assign bus.o_WrThreshold = wr;
    assign bus.o_Threshold   = wr ? th_value : '0;
    assign o_Busy            = busy;
    assign o_Done            = done_q;

`ifdef CTRL_STATS_EN
    logic [31:0] pair_cnt, hit_cnt;

    always_ff @(posedge clk) begin
        if (rst || load_acc) begin
            pair_cnt <= '0;
            hit_cnt  <= '0;
        end else begin
            if (cmp_vld) pair_cnt <= pair_cnt + 32'd1;
            if (bus.i_CmpValid && bus.i_Dout) hit_cnt <= hit_cnt + 32'd1;
        end
    end

    assign o_PairCount = pair_cnt;
    assign o_HitCount  = hit_cnt;
`endif

endmodule

// File: tb/tb_threshold_load_ctrl.sv
// Directed bench for threshold_load_ctrl: reset, fills at several ratios, drain, ignored load, mid-fill reset, stats.
module tb_threshold_load_ctrl;
    localparam int VW = 35;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_Ratio;
    logic       i_Load;
    logic       o_Busy;
    logic       o_Done;
`ifdef CTRL_STATS_EN
    logic [31:0] o_HitCount, o_PairCount;
    logic [10:0] dpat;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    threshold_load_ctrl_if #(.TH_WIDTH(7)) bus();

    threshold_load_ctrl #(
        .VECTOR_WIDTH (VW),
        .FRAC_WIDTH   (8),
        .PIPE_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_Ratio     (i_Ratio),
        .i_Load      (i_Load),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
`ifdef CTRL_STATS_EN
        .o_HitCount  (o_HitCount),
        .o_PairCount (o_PairCount),
`endif
        .bus         (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // ceil((k+1)*r/256), saturated to the 7-bit bus maximum.
    function automatic logic [6:0] exp_th(input logic [7:0] r, input int k);
        int v;
        v = ((k + 1) * int'(r) + 255) / 256;
        if (v > 127) v = 127;
        return 7'(v);
    endfunction

    // Entered at posedge+1 of an IDLE cycle with nothing outstanding; leaves at FILL cycle 0.
    task automatic do_load(input logic [7:0] r);
        i_Load  = 1'b1;
        i_Ratio = r;
        @(negedge clk);
        chk("load_cycle_busy", o_Busy, 0);
        next_cyc();
        i_Load  = 1'b0;
        i_Ratio = ~r;
        @(negedge clk);
        chk("drain_busy", o_Busy, 1);
        chk("drain_ready", bus.o_Ready, 0);
        chk("drain_wr", bus.o_WrThreshold, 0);
`ifdef CTRL_STATS_EN
        chk("stats_pair_clr", o_PairCount, 0);
        chk("stats_hit_clr", o_HitCount, 0);
`endif
        next_cyc();
    endtask

    task automatic check_fill(input logic [7:0] r, input int n, input int load_at, input logic [7:0] r2);
        for (int k = 0; k < n; k++) begin
            i_Load = (k == load_at);
            if (k == load_at) i_Ratio = r2;
            @(negedge clk);
            chk($sformatf("wr[%0d]", k), bus.o_WrThreshold, 1);
            chk($sformatf("th[%0d] r=%0h", k, r), bus.o_Threshold, exp_th(r, k));
            chk($sformatf("done_low[%0d]", k), o_Done, 0);
            next_cyc();
        end
        i_Load = 1'b0;
    endtask

    task automatic finish_fill();
        @(negedge clk);
        chk("done_pulse", o_Done, 1);
        chk("done_ready", bus.o_Ready, 1);
        chk("done_busy", o_Busy, 0);
        chk("done_wr", bus.o_WrThreshold, 0);
        next_cyc();
        @(negedge clk);
        chk("done_single", o_Done, 0);
        chk("idle_busy", o_Busy, 0);
        next_cyc();
    endtask

    initial begin
        rst            = 1'b1;
        i_Ratio        = 8'h00;
        i_Load         = 1'b0;
        bus.i_Valid    = 1'b0;
        bus.i_CmpValid = 1'b0;
`ifdef CTRL_STATS_EN
        bus.i_Dout     = 1'b0;
        dpat           = 11'b110_1110_1101;
`endif
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("rst_ready", bus.o_Ready, 0);
        chk("rst_busy", o_Busy, 0);
        chk("rst_done", o_Done, 0);
        chk("rst_wr", bus.o_WrThreshold, 0);
        chk("rst_th", bus.o_Threshold, 0);
        chk("rst_cmpvalid", bus.o_CmpValid, 0);
`ifdef CTRL_STATS_EN
        chk("rst_pair", o_PairCount, 0);
        chk("rst_hit", o_HitCount, 0);
`endif
        next_cyc();
        rst = 1'b0;

        // No table loaded yet: upstream must stay blocked.
        bus.i_Valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("noload_ready", bus.o_Ready, 0);
            chk("noload_cmpvalid", bus.o_CmpValid, 0);
            next_cyc();
        end
        bus.i_Valid = 1'b0;

        do_load(8'h80);
        check_fill(8'h80, VW, -1, 8'h00);
        finish_fill();

        do_load(8'h00);
        check_fill(8'h00, VW, -1, 8'h00);
        finish_fill();

        do_load(8'hFF);
        check_fill(8'hFF, VW, -1, 8'h00);
        finish_fill();

        // Three pairs in flight, the last one in the load cycle itself.
        bus.i_Valid = 1'b1;
        @(negedge clk);
        chk("inflight_cmpvalid0", bus.o_CmpValid, 1);
        next_cyc();
        @(negedge clk);
        chk("inflight_cmpvalid1", bus.o_CmpValid, 1);
        next_cyc();
        i_Load  = 1'b1;
        i_Ratio = 8'h40;
        @(negedge clk);
        chk("inflight_cmpvalid2", bus.o_CmpValid, 1);
        next_cyc();
        i_Load  = 1'b0;
        i_Ratio = 8'h00;
        @(negedge clk);
        chk("drain3_ready", bus.o_Ready, 0);
        chk("drain3_cmpvalid", bus.o_CmpValid, 0);
        chk("drain3_busy", o_Busy, 1);
        next_cyc();
        @(negedge clk);
        chk("drain3_wait_wr", bus.o_WrThreshold, 0);
        next_cyc();
        for (int c = 0; c < 3; c++) begin
            bus.i_CmpValid = 1'b1;
            @(negedge clk);
            chk($sformatf("drain3_retire%0d_wr", c), bus.o_WrThreshold, 0);
            next_cyc();
        end
        bus.i_CmpValid = 1'b0;
        bus.i_Valid    = 1'b0;
        @(negedge clk);
        chk("drain3_zero_wr", bus.o_WrThreshold, 0);
        chk("drain3_zero_busy", o_Busy, 1);
        next_cyc();
        check_fill(8'h40, VW, -1, 8'h00);
        finish_fill();

        // Load pulsed mid-fill with another ratio must be ignored.
        do_load(8'h60);
        check_fill(8'h60, VW, 10, 8'hF0);
        finish_fill();
        @(negedge clk);
        chk("ignored_load_busy", o_Busy, 0);
        chk("ignored_load_done", o_Done, 0);
        next_cyc();

        // Reset on fill cycle 20.
        do_load(8'h50);
        check_fill(8'h50, 20, -1, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("rst20_wr", bus.o_WrThreshold, 1);
        chk("rst20_th", bus.o_Threshold, exp_th(8'h50, 20));
        next_cyc();
        rst         = 1'b0;
        bus.i_Valid = 1'b1;
        @(negedge clk);
        chk("after_rst_wr", bus.o_WrThreshold, 0);
        chk("after_rst_th", bus.o_Threshold, 0);
        chk("after_rst_busy", o_Busy, 0);
        chk("after_rst_ready", bus.o_Ready, 0);
        chk("after_rst_cmpvalid", bus.o_CmpValid, 0);
        next_cyc();
        @(negedge clk);
        chk("after_rst_ready2", bus.o_Ready, 0);
        next_cyc();
        bus.i_Valid = 1'b0;
        do_load(8'hC0);
        check_fill(8'hC0, VW, -1, 8'h00);
        finish_fill();

`ifdef CTRL_STATS_EN
        // 11 transfers, 11 retirements, 8 of them hits.
        for (int c = 0; c < 12; c++) begin
            bus.i_Valid    = (c < 11);
            bus.i_CmpValid = (c > 0);
            bus.i_Dout     = (c > 0) ? dpat[c-1] : 1'b0;
            next_cyc();
        end
        bus.i_Valid    = 1'b0;
        bus.i_CmpValid = 1'b0;
        bus.i_Dout     = 1'b0;
        @(negedge clk);
        chk("stats_pair", o_PairCount, 11);
        chk("stats_hit", o_HitCount, 8);
        next_cyc();
        do_load(8'h80);
        check_fill(8'h80, VW, -1, 8'h00);
        finish_fill();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
